// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared widths, constants and fetch-state encoding for the
//             pipelined CPU front end.
//  Revision : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam int          c_ADDR_W   = 32;
    localparam int          c_DATA_W   = 32;
    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] c_NOP_INST = 32'h0000_0000;

    // Fetch sequencer states: issue request, await response, park a
    // response that arrived while decode was stalled.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage_if
//  Purpose  : Instruction-memory request/response bus between the fetch
//             stage (master) and instruction memory (slave).
//  Signals  : imem_req    - fetch request, memory always accepts
//             imem_addr   - fetch address
//             imem_rvalid - response valid, at least one cycle after request
//             imem_rdata  - fetched instruction
//  Revision : 1.0  initial release
// ============================================================================
interface fetch_stage_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W
) ();

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_reg
//  Purpose  : IF/ID pipeline register. Priority flush > hold > load > bubble.
//  Ports    : Clk, Reset (async, active-low)
//             load/flush/hold   - slot controls
//             load_addr/inst    - PC and instruction captured on load
//             Addr/Inst         - held PC and instruction
//             if_valid          - slot holds a real instruction
//  Revision : 1.0  initial release
// ============================================================================
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int              ADDR_W   = c_ADDR_W,
    parameter int              DATA_W   = c_DATA_W,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(c_NOP_INST)
) (
    input  wire logic              Clk,
    input  wire logic              Reset,
    input  wire logic              load,
    input  wire logic              flush,
    input  wire logic              hold,
    input  wire logic [ADDR_W-1:0] load_addr,
    input  wire logic [DATA_W-1:0] load_inst,
    output logic      [ADDR_W-1:0] Addr,
    output logic      [DATA_W-1:0] Inst,
    output logic                   if_valid
);

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_inst;
    logic              r_valid;

    // Bubbles keep the last Addr; only Inst and if_valid mark the slot empty.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_addr  <= '0;
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end else if (flush) begin
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end else if (hold) begin
            r_addr  <= r_addr;
        end else if (load) begin
            r_addr  <= load_addr;
            r_inst  <= load_inst;
            r_valid <= 1'b1;
        end else begin
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end
    end

    assign Addr     = r_addr;
    assign Inst     = r_inst;
    assign if_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction fetch plus IF/ID register. Owns the PC, keeps at
//             most one instruction-memory request outstanding, honours the
//             load-use stall and takes branch/jump redirects from decode.
//  Ports    : Clk, Reset (async, active-low)
//             stall_i                      - hold PC and IF/ID
//             redirect_valid/redirect_addr - taken branch/jump pulse + target
//             imem (master)                - instruction-memory bus
//             Addr/Inst/if_valid           - IF/ID contents to decode
//             pc_plus4                     - Addr + 4
//  Revision : 1.0  initial release
// ============================================================================
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = c_ADDR_W,
    parameter int                DATA_W   = c_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(c_RESET_PC),
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(c_NOP_INST)
) (
    input  wire logic              Clk,
    input  wire logic              Reset,
    input  wire logic              stall_i,
    input  wire logic              redirect_valid,
    input  wire logic [ADDR_W-1:0] redirect_addr,
    fetch_stage_if.master          imem,
    output logic      [ADDR_W-1:0] Addr,
    output logic      [DATA_W-1:0] Inst,
    output logic                   if_valid,
    output logic      [ADDR_W-1:0] pc_plus4
);

    fetch_state_t      r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    logic              r_discard, w_discard_nxt;
    logic [DATA_W-1:0] r_hold_buf, w_hold_buf_nxt;

    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_target;
    logic              w_req;
    logic [ADDR_W-1:0] w_req_addr;
    logic              w_load, w_flush, w_hold;
    logic [DATA_W-1:0] w_load_inst;

    assign w_pc_inc = r_pc + ADDR_W'(4);
    // Targets are forced onto a word boundary.
    assign w_target = redirect_addr & ~ADDR_W'(3);

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_discard_nxt  = r_discard;
        w_hold_buf_nxt = r_hold_buf;
        w_req          = 1'b0;
        w_req_addr     = r_pc;
        w_load         = 1'b0;
        w_flush        = 1'b0;
        w_hold         = 1'b0;
        w_load_inst    = imem.imem_rdata;

        case (r_state)
            S_REQ: begin
                if (redirect_valid) begin
                    // Request already goes out with the old PC; its
                    // response is marked for discard.
                    w_req         = 1'b1;
                    w_flush       = 1'b1;
                    w_pc_nxt      = w_target;
                    w_discard_nxt = 1'b1;
                    w_state_nxt   = S_WAIT;
                end else if (stall_i) begin
                    w_hold        = 1'b1;
                end else begin
                    w_req         = 1'b1;
                    w_state_nxt   = S_WAIT;
                end
            end

            S_WAIT: begin
                if (redirect_valid) begin
                    w_flush  = 1'b1;
                    w_pc_nxt = w_target;
                    if (imem.imem_rvalid) begin
                        // Outstanding response retires now, nothing
                        // left to discard.
                        w_discard_nxt = 1'b0;
                        w_state_nxt   = S_REQ;
                    end else begin
                        w_discard_nxt = 1'b1;
                    end
                end else if (imem.imem_rvalid && r_discard) begin
                    w_discard_nxt = 1'b0;
                    w_state_nxt   = S_REQ;
                    w_hold        = stall_i;
                end else if (imem.imem_rvalid && stall_i) begin
                    w_hold_buf_nxt = imem.imem_rdata;
                    w_hold         = 1'b1;
                    w_state_nxt    = S_HOLD;
                end else if (imem.imem_rvalid) begin
                    // Back-to-back: next request overlaps the IF/ID load.
                    w_load     = 1'b1;
                    w_pc_nxt   = w_pc_inc;
                    w_req      = 1'b1;
                    w_req_addr = w_pc_inc;
                end else begin
                    w_hold = stall_i;
                end
            end

            S_HOLD: begin
                if (redirect_valid) begin
                    w_flush     = 1'b1;
                    w_pc_nxt    = w_target;
                    w_state_nxt = S_REQ;
                end else if (stall_i) begin
                    w_hold = 1'b1;
                end else begin
                    w_load      = 1'b1;
                    w_load_inst = r_hold_buf;
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = S_REQ;
                end
            end

            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_discard  <= 1'b0;
            r_hold_buf <= NOP_INST;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_discard  <= w_discard_nxt;
            r_hold_buf <= w_hold_buf_nxt;
        end
    end

    // Reset is in REQ, but no request may be visible until reset releases.
    assign imem.imem_req  = w_req & Reset;
    assign imem.imem_addr = w_req_addr;

    if_id_reg #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .Clk       (Clk),
        .Reset     (Reset),
        .load      (w_load),
        .flush     (w_flush),
        .hold      (w_hold),
        .load_addr (r_pc),
        .load_inst (w_load_inst),
        .Addr      (Addr),
        .Inst      (Inst),
        .if_valid  (if_valid)
    );

    assign pc_plus4 = Addr + ADDR_W'(4);

    // A response is only legal while a request is outstanding.
    a_rvalid_in_wait : assert property (
        @(posedge Clk) disable iff (!Reset)
        imem.imem_rvalid |-> (r_state == S_WAIT)
    );

endmodule
`default_nettype wire
